// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl -- sequencing controller for the radix-2 Viterbi decoder core.
//
// For each frame it handshakes received symbols in from the input buffer and
// fires the BMU and, one cycle later, the ACS once per trellis step with the
// survivor-memory write address. After one flush cycle, it captures the ACS
// best end-state. It then walks the traceback unit backwards through survivor
// memory, and pulses o_done at the end.
//
// Optional feature: define VITERBI_CTRL_ABORT_EN to add the i_abort port.
// While the controller is busy, i_abort returns it to IDLE on the next edge
// with no o_done pulse.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_start         start-of-frame request (IDLE only)
//   i_frame_len     trellis steps in the frame, 1..MAX_FRAME
//   i_sym_valid     input buffer has a symbol
//   o_sym_ready     controller accepts a symbol this cycle
//   o_en_bmu        branch-metric enable, one per accepted symbol
//   o_en_acs        ACS enable, one cycle after o_en_bmu
//   o_wr_addr       survivor-memory write address (with o_en_acs)
//   i_sel_node      best end-state from the ACS
//   o_tb_start_st   latched traceback start state
//   o_en_tbu        traceback enable
//   o_rd_addr       survivor-memory read address (with o_en_tbu)
//   o_busy          high whenever not IDLE
//   o_done          one-cycle end-of-frame pulse
//   i_abort         (VITERBI_CTRL_ABORT_EN only) abandon the current frame
module viterbi_ctrl #(
  parameter int MAX_FRAME = 255,
  parameter int ST_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [7:0]      i_frame_len,
  input  logic            i_sym_valid,
  output logic            o_sym_ready,
  output logic            o_en_bmu,
  output logic            o_en_acs,
  output logic [7:0]      o_wr_addr,
  input  logic [ST_W-1:0] i_sel_node,
  output logic [ST_W-1:0] o_tb_start_st,
  output logic            o_en_tbu,
  output logic [7:0]      o_rd_addr,
  output logic            o_busy,
  output logic            o_done
`ifdef VITERBI_CTRL_ABORT_EN
  ,
  input  logic            i_abort
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACS   = 3'd1,
    FLUSH = 3'd2,
    CAPT  = 3'd3,
    TB    = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state, state_d;
  logic [7:0] len;
  logic [7:0] step;
  logic [7:0] step_nxt;
  logic [7:0] rd;
  logic       hs;
  logic       start_ok;
  logic       abort;

`ifdef VITERBI_CTRL_ABORT_EN
  assign abort = i_abort && (state != IDLE);
`else
  assign abort = 1'b0;
`endif

  assign start_ok = i_start && (i_frame_len != '0) && (int'(i_frame_len) <= MAX_FRAME);
  assign hs       = i_sym_valid && (state == ACS);
  assign step_nxt = step + 8'd1;

  // Combinational outputs decode the state register directly, so an
  // asynchronous reset drops them in the same instant.
  assign o_sym_ready = (state == ACS);
  assign o_en_bmu    = hs;
  assign o_en_tbu    = (state == TB);
  assign o_rd_addr   = rd;
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start_ok) state_d = ACS;
      ACS:     if (hs && (step_nxt == len)) state_d = FLUSH;
      FLUSH:   state_d = CAPT;
      CAPT:    state_d = TB;
      TB:      if (rd == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len           <= '0;
      step          <= '0;
      rd            <= '0;
      o_en_acs      <= 1'b0;
      o_wr_addr     <= '0;
      o_tb_start_st <= '0;
    end else begin
      // The ACS enable is a delayed handshake; an abort must not let the
      // last one leak out after the controller has gone idle.
      o_en_acs <= hs && !abort;
      if ((state == IDLE) && start_ok) begin
        len  <= i_frame_len;
        step <= '0;
      end
      if (hs) begin
        o_wr_addr <= step;
        step      <= step_nxt;
      end
      // Traceback walks len-1 down to 0; the counter is loaded while the
      // start state is captured so TB can present it on its first cycle.
      if ((state == CAPT) && !abort) begin
        o_tb_start_st <= i_sel_node;
        rd            <= len - 8'd1;
      end
      if ((state == TB) && (rd != '0)) rd <= rd - 8'd1;
    end
  end

endmodule

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Sequencing controller for the radix-2 Viterbi decoder core. For each frame it handshakes received symbols in from the input buffer and enables the branch-metric unit and add-compare-select unit once per trellis step. It then captures the ACS best-state selection and walks the traceback unit backwards through survivor memory. It sits between the frame input buffer and the BMU/ACS/TBU datapath and owns all enables and survivor-memory addressing.

## Interface
Parameters:
- `MAX_FRAME`, 255: maximum trellis steps per frame; sets the counter range.
- `ST_W`, 8: width of a trellis state index; matches the ACS selected-node output.

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  start-of-frame request, sampled in IDLE only.
- `i_frame_len`  in  8  trellis steps in the frame, sampled with `i_start`; valid range 1..`MAX_FRAME`.
- `i_sym_valid`  in  1  input buffer has a symbol.
- `o_sym_ready`  out  1  controller accepts a symbol this cycle.
- `o_en_bmu`  out  1  branch-metric enable, one per accepted symbol.
- `o_en_acs`  out  1  ACS enable, one cycle after `o_en_bmu`.
- `o_wr_addr`  out  8  survivor-memory write address, aligned with `o_en_acs`.
- `i_sel_node`  in  `ST_W`  best end-state from the ACS.
- `o_tb_start_st`  out  `ST_W`  latched traceback start state.
- `o_en_tbu`  out  1  traceback enable.
- `o_rd_addr`  out  8  survivor-memory read address, aligned with `o_en_tbu`.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_done`  out  1  one-cycle pulse at frame end.
- `i_abort`  in  1  present only with `VITERBI_CTRL_ABORT_EN`.

## Operation
- States: IDLE, ACS, FLUSH, CAPT, TB, DONE.
- IDLE: `i_start`=1 and `i_frame_len`≠0 latches `len`, clears `step`, and moves to ACS. A `len` of 0, or a value above `MAX_FRAME`, is ignored and the controller stays in IDLE.
- ACS:
  - `o_sym_ready`=1.
  - Handshake is `i_sym_valid & o_sym_ready`. On handshake, `o_en_bmu` is high that cycle and `step` increments.
  - When the handshake makes `step`==`len`, the next state is FLUSH and `o_sym_ready` drops in that next cycle.
  - No handshake means no enables; the controller stalls indefinitely.
- `o_en_acs` and `o_wr_addr` are registered copies of the handshake and of `step` before its increment. Write addresses run 0..len-1.
- FLUSH: exactly one cycle. The final `o_en_acs` fires here.
- CAPT: exactly one cycle. `o_tb_start_st` ← `i_sel_node`. `i_sel_node` is treated as valid in the cycle after the last `o_en_acs`.
- TB: `o_en_tbu`=1 for exactly `len` cycles. `o_rd_addr` runs len-1 down to 0, then the state moves to DONE.
- DONE: `o_done`=1 for one cycle, then IDLE.
- `i_start` outside IDLE is ignored.
- `i_frame_len` changes after the start cycle have no effect.
- Counters are 8-bit. `step` never wraps because `len`≤255.

## Timing
- Reset values: all outputs 0, state IDLE, `o_tb_start_st`=0, counters 0.
- Reset asserted mid-frame returns to IDLE asynchronously and drops every enable immediately. Any partial frame is discarded.
- Latency (`len`=N, symbols back-to-back):
  - start cycle is T0;
  - `o_sym_ready` high T1..TN;
  - `o_en_acs` high T2..TN+1;
  - CAPT at TN+2;
  - TB TN+3..T2N+2;
  - `o_done` at T2N+3.
- Minimum frame-to-frame gap: `i_start` may be reasserted in the cycle after `o_done`.
- `o_busy` deasserts in the cycle `o_done` is low again, i.e. when back in IDLE.

## Configuration
- `VITERBI_CTRL_ABORT_EN` defined:
  - Port `i_abort` exists.
  - `i_abort`=1 in any non-IDLE state forces IDLE on the next edge. All enables are 0 from that edge on, and no `o_done` pulse is produced.
  - Abort takes priority over every other transition, including the DONE→IDLE transition. `i_abort` in IDLE has no effect.
- Not defined: no `i_abort` port, and frames always run to completion.

## Test plan
- `i_frame_len`=4, `i_sym_valid` held 1 → 4 `o_en_bmu`, `o_en_acs` with `o_wr_addr` 0,1,2,3; `o_rd_addr` 3,2,1,0; `o_done` at T11.
- `len`=3, `i_sym_valid` toggled 1,0,0,1,0,1 → exactly 3 handshakes and no enables in stall cycles. `i_sel_node`=8'hA5 in the CAPT cycle → `o_tb_start_st`=8'hA5.
- `i_start` with `i_frame_len`=0 → stays IDLE and `o_busy`=0. `i_start` pulsed during TB → ignored, with a single `o_done`.
- `len`=255 back-to-back → `o_wr_addr` reaches 254 without wrap; traceback starts `o_rd_addr`=254 and ends at 0.
- `rst` pulsed during ACS step 2 → all outputs 0 immediately. A following `len`=2 frame completes normally.
- With `VITERBI_CTRL_ABORT_EN`: `i_abort` during TB → IDLE next edge, `o_en_tbu` low, no `o_done`.
